// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes for the regfile, decode and writeback arbiter.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  function automatic int wrap_idx(input logic [IW-1:0] base, input int offs);
    return (int'(base) + offs) % N;
  endfunction

  // Scan from farthest to nearest so the requester closest to ptr is written last and wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        gnt                   = '0;
        gnt[wrap_idx(ptr, k)] = 1'b1;
        gnt_idx               = IW'(wrap_idx(ptr, k));
        any                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter with registered regfile write stage and pending-write scoreboard.
// Optional same-cycle forwarding of the write stage is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0]     req_data,
  input  logic                     alloc_en,
  input  logic [REG_ADDR_W-1:0]    alloc_rd,
  output logic [NUM_REGS-1:0]      pending,
  output logic                     write,
  output logic [REG_ADDR_W-1:0]    writenum,
  output logic [XLEN-1:0]          data_in
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0]    fwd_num,
  output logic                     fwd_hit,
  output logic [XLEN-1:0]          fwd_data
`endif
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       gnt_idx;
  logic [NREQ-1:0]     req_live;
  logic [NREQ-1:0]     gnt;
  logic                any_gnt;
  reg_addr_t           win_rd;
  logic [XLEN-1:0]     win_data;
  logic                win_writes;
  logic [NUM_REGS-1:0] pending_nxt;

  // Reset must drop ready immediately, even though valid may still be high.
  assign req_live = req_valid & {NREQ{~reset}};

  rr_arbiter #(.N(NREQ), .IW(PW)) u_arb (
    .req     (req_live),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_gnt)
  );

  assign req_ready  = gnt;
  assign win_rd     = req_rd[gnt_idx*REG_ADDR_W +: REG_ADDR_W];
  assign win_data   = req_data[gnt_idx*XLEN +: XLEN];
  // An X0 writeback is consumed but never reaches the regfile.
  assign win_writes = any_gnt && (win_rd != '0);

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_gnt) begin
      rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Index and data hold when nothing is written, so only the enable toggles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write    <= 1'b0;
      writenum <= '0;
      data_in  <= '0;
    end else begin
      write <= win_writes;
      if (win_writes) begin
        writenum <= win_rd;
        data_in  <= win_data;
      end
    end
  end

  // Set after clear: a newly issued producer of rd outranks the one retiring this cycle.
  always_comb begin
    pending_nxt = pending;
    if (win_writes) pending_nxt[win_rd] = 1'b0;
    if (alloc_en && (alloc_rd != '0)) pending_nxt[alloc_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_hit  = write && (writenum == fwd_num) && (fwd_num != '0);
  assign fwd_data = fwd_hit ? data_in : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed cases followed by randomized traffic.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*5-1:0] req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic              alloc_en;
  logic [4:0]        alloc_rd;
  logic [31:0]       pending;
  logic              write;
  logic [4:0]        writenum;
  logic [XLEN-1:0]   data_in;
  logic [4:0]        fwd_num;
`ifdef REGFILE_WB_BYPASS_EN
  logic              fwd_hit;
  logic [XLEN-1:0]   fwd_data;
`endif

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .alloc_en  (alloc_en),
    .alloc_rd  (alloc_rd),
    .pending   (pending),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .fwd_num   (fwd_num),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: requester contents, rotation pointer, outstanding-write set.
  logic [NREQ-1:0] valid_r;
  logic [4:0]      rd_r   [NREQ];
  logic [XLEN-1:0] data_r [NREQ];
  int              m_ptr;
  logic [31:0]     m_pend;
  int              last_gnt;
  logic [NREQ-1:0] obs_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++)
      if (valid_r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]             = valid_r[i];
      req_rd[i*5 +: 5]         = rd_r[i];
      req_data[i*XLEN +: XLEN] = data_r[i];
    end
  endtask

  // One clock: check grant and scoreboard mid-cycle, then advance the model past the edge.
  task automatic step();
    int              g;
    logic [NREQ-1:0] exp_ready;
    exp_t            e;
    drive();
    @(negedge clk);
    g         = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    obs_ready = req_ready;
    check("req_ready", req_ready, exp_ready);
    check("pending", pending, m_pend);
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (rd_r[g] != 5'd0) begin
        e.rd   = rd_r[g];
        e.data = data_r[g];
        exp_q.push_back(e);
        m_pend[rd_r[g]] = 1'b0;
      end
      m_ptr = (g + 1) % NREQ;
    end
    if (alloc_en && alloc_rd != 5'd0) m_pend[alloc_rd] = 1'b1;
    last_gnt = g;
  endtask

  // Monitor: every write the DUT presents must match the oldest expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (write) begin
          if (exp_q.size() == 0) begin
            check("spurious_write", {59'd0, writenum}, 64'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("writenum", writenum, e.rd);
            check("data_in", data_in, e.data);
`ifdef REGFILE_WB_BYPASS_EN
            check("fwd_hit", fwd_hit, fwd_num == e.rd);
            check("fwd_data", fwd_data, (fwd_num == e.rd) ? e.data : '0);
`endif
          end
        end else begin
`ifdef REGFILE_WB_BYPASS_EN
          check("fwd_hit_idle", fwd_hit, 1'b0);
`endif
        end
      end
    end
  end

  task automatic idle(input int n);
    valid_r  = '0;
    alloc_en = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    reset    = 1'b1;
    valid_r  = '0;
    alloc_en = 1'b0;
    alloc_rd = '0;
    fwd_num  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd_r[i]   = '0;
      data_r[i] = '0;
    end
    drive();
    m_ptr    = 0;
    m_pend   = '0;
    last_gnt = -1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_write", write, 1'b0);
    check("rst_pending", pending, 32'd0);
    check("rst_writenum", writenum, 5'd0);
    reset = 1'b0;

    // Contention: both valid, requester 0 first, then requester 1.
    valid_r   = 2'b11;
    rd_r[0]   = 5'd5; data_r[0] = 32'hAAAA;
    rd_r[1]   = 5'd6; data_r[1] = 32'h5555;
    step();
    check("t2_cycle1_ready", obs_ready, 2'b01);
    valid_r[0] = 1'b0;
    step();
    check("t2_cycle2_ready", obs_ready, 2'b10);
    idle(2);

    // X0 request is consumed without a regfile write.
    valid_r   = 2'b01;
    rd_r[0]   = 5'd0; data_r[0] = 32'hDEAD;
    step();
    check("t3_ready", obs_ready, 2'b01);
    valid_r = '0;
    step();
    check("t3_no_write", write, 1'b0);
    idle(1);

    // Scoreboard set, clear, and same-cycle set-wins.
    alloc_en = 1'b1; alloc_rd = 5'd7;
    step();
    alloc_en = 1'b0;
    check("t4_set", pending[7], 1'b1);
    valid_r = 2'b01; rd_r[0] = 5'd7; data_r[0] = 32'h7777;
    step();
    valid_r = '0;
    check("t4_clear", pending[7], 1'b0);
    valid_r = 2'b01; alloc_en = 1'b1; alloc_rd = 5'd7;
    step();
    valid_r = '0; alloc_en = 1'b0;
    check("t4_set_wins", pending[7], 1'b1);
    idle(2);

`ifdef REGFILE_WB_BYPASS_EN
    valid_r = 2'b01; rd_r[0] = 5'd9; data_r[0] = 32'h1234;
    step();
    valid_r = '0;
    fwd_num = 5'd9;
    #1;
    check("t6_hit", fwd_hit, 1'b1);
    check("t6_data", fwd_data, 32'h1234);
    fwd_num = 5'd0;
    #1;
    check("t6_x0_miss", fwd_hit, 1'b0);
    idle(1);
`endif

    // Randomized traffic; a losing requester holds rd/data until it is granted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!valid_r[i] || last_gnt == i) begin
          valid_r[i] = ($urandom_range(0, 9) < 6);
          rd_r[i]    = 5'($urandom_range(0, 31));
          data_r[i]  = $urandom;
        end
      end
      alloc_en = ($urandom_range(0, 3) == 0);
      alloc_rd = 5'($urandom_range(0, 31));
      fwd_num  = 5'($urandom_range(0, 31));
      step();
      if (n == 200) begin
        // Reset mid-transfer with both requesters valid.
        valid_r = 2'b11;
        drive();
        reset = 1'b1;
        #1;
        check("midrst_write", write, 1'b0);
        check("midrst_pending", pending, 32'd0);
        check("midrst_ready", req_ready, 2'b00);
        exp_q.delete();
        m_pend   = '0;
        m_ptr    = 0;
        last_gnt = -1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("midrst_ptr0_ready", obs_ready, 2'b01);
      end
    end

    idle(3);
    check("drain_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
